// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: CSR addresses, mstatus bit
// positions, mcause field widths and the CSR read-modify-write operation.
package wb_stage_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int MCAUSE_CODE_W = 4;
    localparam int MCAUSE_PAD_W  = 32 - 1 - MCAUSE_CODE_W;

    typedef enum logic [1:0] {
        CSR_OP_NONE,
        CSR_OP_WRITE,
        CSR_OP_SET,
        CSR_OP_CLEAR
    } csr_op_e;

    function automatic logic [31:0] csr_apply(input csr_op_e op,
                                              input logic [31:0] old_val,
                                              input logic [31:0] info);
        case (op)
            CSR_OP_WRITE: csr_apply = info;
            CSR_OP_SET:   csr_apply = old_val | info;
            CSR_OP_CLEAR: csr_apply = old_val & ~info;
            default:      csr_apply = old_val;
        endcase
    endfunction

endpackage

// File: rtl/wb_stage_csr_file.sv
// Machine-mode CSR file: registers, read mux, RMW update, trap entry and mret.
// Optional 64-bit mcycle/minstret counters are built when WB_COUNTERS_EN is defined.
module csr_file
    import wb_stage_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     i_ret,
    input  logic                     i_trap,
    input  logic                     i_mret,
    input  csr_op_e                  i_csr_op,
    input  logic [11:0]              i_csr_addr,
    input  logic [31:0]              i_csr_info,
    input  logic [31:0]              i_pc,
    input  logic [MCAUSE_CODE_W-1:0] i_exc_code,
    input  logic [31:0]              i_exc_tval,
    input  logic                     i_exc_interrupt,
    output logic [31:0]              o_csr_rdata,
    output logic [31:0]              o_mtvec,
    output logic [31:0]              o_mepc,
    output logic [31:0]              o_mie,
    output logic                     o_mstatus_mie
);

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:2] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:2] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;

    logic        w_csr_wr;
    logic [31:0] w_csr_new;
    logic [1:0]  w_unused_pc_lsb;

    // mret outranks a CSR op on the same instruction; traps never reach i_ret.
    assign w_csr_wr        = i_ret & ~i_mret & (i_csr_op != CSR_OP_NONE);
    assign w_csr_new       = csr_apply(i_csr_op, o_csr_rdata, i_csr_info);
    assign w_unused_pc_lsb = i_pc[1:0];

    assign o_mtvec       = {r_mtvec, 2'b00};
    assign o_mepc        = {r_mepc, 2'b00};
    assign o_mie         = r_mie;
    assign o_mstatus_mie = r_mstatus_mie;

`ifdef WB_COUNTERS_EN
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            if (w_csr_wr && i_csr_addr == CSR_MCYCLE)
                r_mcycle <= {r_mcycle[63:32], w_csr_new};
            else if (w_csr_wr && i_csr_addr == CSR_MCYCLEH)
                r_mcycle <= {w_csr_new, r_mcycle[31:0]};
            else
                r_mcycle <= r_mcycle + 64'd1;

            if (w_csr_wr && i_csr_addr == CSR_MINSTRET)
                r_minstret <= {r_minstret[63:32], w_csr_new};
            else if (w_csr_wr && i_csr_addr == CSR_MINSTRETH)
                r_minstret <= {w_csr_new, r_minstret[31:0]};
            else
                r_minstret <= r_minstret + {63'd0, i_ret};
        end
    end
`endif

    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        o_csr_rdata = '0;
        case (i_csr_addr)
            CSR_MSTATUS: begin
                o_csr_rdata[MSTATUS_MIE]                   = r_mstatus_mie;
                o_csr_rdata[MSTATUS_MPIE]                  = r_mstatus_mpie;
                o_csr_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
            end
            CSR_MIE:      o_csr_rdata = r_mie;
            CSR_MTVEC:    o_csr_rdata = {r_mtvec, 2'b00};
            CSR_MSCRATCH: o_csr_rdata = r_mscratch;
            CSR_MEPC:     o_csr_rdata = {r_mepc, 2'b00};
            CSR_MCAUSE:   o_csr_rdata = r_mcause;
            CSR_MTVAL:    o_csr_rdata = r_mtval;
`ifdef WB_COUNTERS_EN
            CSR_MCYCLE, CSR_CYCLE:       o_csr_rdata = r_mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:     o_csr_rdata = r_mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:   o_csr_rdata = r_minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: o_csr_rdata = r_minstret[63:32];
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_b) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mtvec        <= MTVEC_RESET[31:2];
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
        end else if (i_trap) begin
            r_mepc         <= i_pc[31:2];
            r_mcause       <= {i_exc_interrupt, {MCAUSE_PAD_W{1'b0}}, i_exc_code};
            r_mtval        <= i_exc_tval;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (i_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_csr_wr) begin
            case (i_csr_addr)
                CSR_MSTATUS: begin
                    r_mstatus_mie  <= w_csr_new[MSTATUS_MIE];
                    r_mstatus_mpie <= w_csr_new[MSTATUS_MPIE];
                end
                CSR_MIE:      r_mie      <= w_csr_new;
                CSR_MTVEC:    r_mtvec    <= w_csr_new[31:2];
                CSR_MSCRATCH: r_mscratch <= w_csr_new;
                CSR_MEPC:     r_mepc     <= w_csr_new[31:2];
                CSR_MCAUSE:   r_mcause   <= w_csr_new;
                CSR_MTVAL:    r_mtval    <= w_csr_new;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wb_stage.sv
// RV32 write-back stage: retire qualification, rd mux and forwarding, flush and
// trap/mret redirect. CSR state lives in csr_file; WB_COUNTERS_EN adds counters.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        rst_b,
    output logic        wb_pipe_ready,
    output logic        wb_pipe_flush,
    input  logic        wb_pipe_valid,
    input  logic [31:0] wb_pipe_pc,
    input  logic [31:0] wb_pipe_instruction,
    input  logic        wb_pipe_rd_write,
    input  logic [4:0]  wb_pipe_rd_addr,
    input  logic [31:0] wb_pipe_rd_data,
    input  logic        wb_pipe_csr_write,
    input  logic        wb_pipe_csr_set,
    input  logic        wb_pipe_csr_clear,
    input  logic        wb_pipe_csr_read,
    input  logic [31:0] wb_pipe_csr_info,
    input  logic [11:0] wb_pipe_csr_addr,
    input  logic        wb_pipe_mret,
    input  logic        wb_pipe_exc_pending,
    input  logic [3:0]  wb_pipe_exc_code,
    input  logic [31:0] wb_pipe_exc_tval,
    input  logic        wb_pipe_exc_interrupt,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        wb_rd_write,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] wb_rd_wdata,
    output logic        trap_redirect,
    output logic [31:0] trap_pc,
    output logic        csr_mstatus_mie,
    output logic [31:0] csr_mie
);

    logic        w_live;
    logic        w_ret;
    logic        w_trap;
    logic        w_mret;
    csr_op_e     w_csr_op;
    logic [31:0] w_csr_rdata;
    logic [31:0] w_mtvec;
    logic [31:0] w_mepc;
    logic        w_unused_instr;

    // Gating with rst_b keeps writes and redirects quiet while reset is held.
    assign w_live = rst_b & wb_pipe_valid;
    assign w_trap = w_live & wb_pipe_exc_pending;
    assign w_mret = w_live & wb_pipe_mret & ~wb_pipe_exc_pending;
    assign w_ret  = w_live & ~wb_pipe_exc_pending;

    assign w_unused_instr = ^wb_pipe_instruction;

    always_comb begin
        w_csr_op = CSR_OP_NONE;
        if (wb_pipe_csr_write)      w_csr_op = CSR_OP_WRITE;
        else if (wb_pipe_csr_set)   w_csr_op = CSR_OP_SET;
        else if (wb_pipe_csr_clear) w_csr_op = CSR_OP_CLEAR;
    end

    csr_file #(
        .MTVEC_RESET(MTVEC_RESET)
    ) u_csr_file (
        .clk            (clk),
        .rst_b          (rst_b),
        .i_ret          (w_ret),
        .i_trap         (w_trap),
        .i_mret         (w_mret),
        .i_csr_op       (w_csr_op),
        .i_csr_addr     (wb_pipe_csr_addr),
        .i_csr_info     (wb_pipe_csr_info),
        .i_pc           (wb_pipe_pc),
        .i_exc_code     (wb_pipe_exc_code),
        .i_exc_tval     (wb_pipe_exc_tval),
        .i_exc_interrupt(wb_pipe_exc_interrupt),
        .o_csr_rdata    (w_csr_rdata),
        .o_mtvec        (w_mtvec),
        .o_mepc         (w_mepc),
        .o_mie          (csr_mie),
        .o_mstatus_mie  (csr_mstatus_mie)
    );

    assign wb_pipe_ready = 1'b1;
    assign wb_pipe_flush = w_trap | w_mret;
    assign trap_redirect = wb_pipe_flush;
    assign trap_pc       = w_trap ? w_mtvec : w_mepc;

    assign rf_wen   = w_ret & wb_pipe_rd_write & (wb_pipe_rd_addr != 5'd0);
    assign rf_waddr = wb_pipe_rd_addr;
    assign rf_wdata = wb_pipe_csr_read ? w_csr_rdata : wb_pipe_rd_data;

    assign wb_rd_write = rf_wen;
    assign wb_rd_addr  = rf_waddr;
    assign wb_rd_wdata = rf_wdata;

endmodule
